ddr3_cmd_arbiter: RTL
=====================

DDR3_CMD_ARBITER -- requirements
Module: ddr3_cmd_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_BANKS, 8, bank requesters
- ROW_W, 14, row address width
- COL_W, 10, column address width
- tRRD_CYCLES, 4, minimum spacing between ACT commands
- tCCD_CYCLES, 4, minimum spacing between RD/WR commands
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock
- rst_n, in, 1, asynchronous active-low reset
- bank_req, in, NUM_BANKS, per-bank command request
- bank_cmd, in, 3*NUM_BANKS, per-bank command code
- bank_row, in, ROW_W*NUM_BANKS, per-bank row address
- bank_col, in, COL_W*NUM_BANKS, per-bank column address
- bank_grant, out, NUM_BANKS, one-hot one-cycle grant
- refresh_cmd_valid, in, 1, one-cycle REF request pulse
- refresh_imminent, in, 1, suppress new ACTs
- refresh_issued, out, 1, one-cycle pulse when REF driven
- cmd_valid, out, 1, command bus valid
- cmd_type, out, 3, command code
- cmd_bank, out, $clog2(NUM_BANKS), target bank
- cmd_addr, out, max(ROW_W,COL_W), row (ACT) or column (RD/WR), else 0
REQ-003 Command codes: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF; 6/7 illegal.

Function
REQ-004 At most one command per cycle; cmd_valid, cmd_type, cmd_bank, cmd_addr, bank_grant and refresh_issued are registered and change together.
REQ-005 A request sampled at edge N is issued in cycle N+1: cmd outputs and the matching bank_grant bit both high in that cycle.
REQ-006 A requester holds bank_req and its fields stable until granted; the bank whose grant bit is currently high is excluded from arbitration that cycle.
REQ-007 refresh_cmd_valid is latched into a ref_pending flag; a pulse arriving while ref_pending is set is absorbed and never produces a second REF.
REQ-008 ref_pending has absolute priority: on the next edge, REF is issued (cmd_type=5, cmd_bank=0, cmd_addr=0, refresh_issued=1, bank_grant=0) and ref_pending clears.
REQ-009 While ref_pending is set, no bank is granted.
REQ-010 While refresh_imminent=1, ACT requests are ineligible; RD, WR and PRE remain eligible.
REQ-011 ACT is ineligible until tRRD_CYCLES cycles after the last issued ACT: ACT at cycle T, next ACT no earlier than T+tRRD_CYCLES; saturating counter, no wrap.
REQ-012 RD/WR are ineligible until tCCD_CYCLES cycles after the last issued RD/WR, using the same rule and a separate counter.
REQ-013 Eligible = bank_req, not excluded, legal code, timing met. Among eligible banks, round-robin starting at rr_ptr; rr_ptr becomes (granted bank+1) mod NUM_BANKS; REF issue leaves rr_ptr unchanged.
REQ-014 Requests with an illegal code (0, 5, 6, 7) are never granted and do not block other banks.
REQ-015 No eligible request and no ref_pending -> NOP cycle: cmd_valid=0, cmd_type=0, cmd_bank=0, cmd_addr=0, grant=0.
REQ-016 If refresh_cmd_valid and bank requests arrive at the same edge, REF wins; banks are arbitrated after REF issues.
REQ-017 Timing counters keep counting during REF and NOP cycles.

Reset
REQ-018 On rst_n low, asynchronously:
- all outputs 0
- ref_pending=0, rr_ptr=0
- tRRD and tCCD counters saturated (first ACT/RD/WR immediately eligible)
REQ-019 Reset mid-operation drops any pending REF or in-flight grant; no command is issued in the first cycle after release.

Verification
REQ-020 Scenario list:
- Reset, then bank 3 requests ACT row 0x1A5 at edge 0 -> cycle 1: cmd_valid=1, type=1, bank=3, addr=0x1A5, bank_grant=0x08.
- Banks 1 and 5 hold RD from reset; 3 grant rounds -> order 1, 5, 1, with consecutive RDs spaced exactly 4 cycles.
- Banks 0 and 2 request ACT in the same cycle -> grants 4 cycles apart, never closer.
- refresh_cmd_valid at the same edge as bank 2 WR -> REF next cycle with refresh_issued=1, WR the cycle after.
- refresh_imminent=1 with bank 4 ACT and bank 6 PRE -> PRE granted, ACT withheld until refresh_imminent=0.
- rst_n asserted while ref_pending=1 -> no REF after release; outputs 0.

Source files
------------

// File: rtl/ddr3_cmd_arbiter.sv
// DDR3 command arbiter: round-robin bank grant with REF priority
// and tRRD/tCCD spacing on a single registered command bus.
module ddr3_cmd_arbiter #(
  parameter int NUM_BANKS   = 8,
  parameter int ROW_W       = 14,
  parameter int COL_W       = 10,
  parameter int tRRD_CYCLES = 4,
  parameter int tCCD_CYCLES = 4,
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int AW = (ROW_W > COL_W) ? ROW_W : COL_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_BANKS-1:0]     bank_req,
  input  logic [3*NUM_BANKS-1:0]   bank_cmd,
  input  logic [ROW_W*NUM_BANKS-1:0] bank_row,
  input  logic [COL_W*NUM_BANKS-1:0] bank_col,
  output logic [NUM_BANKS-1:0]     bank_grant,
  input  logic                     refresh_cmd_valid,
  input  logic                     refresh_imminent,
  output logic                     refresh_issued,
  output logic                     cmd_valid,
  output logic [2:0]               cmd_type,
  output logic [BW-1:0]            cmd_bank,
  output logic [AW-1:0]            cmd_addr
);

  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;
  localparam logic [2:0] C_REF = 3'd5;

  localparam int RRD_W = $clog2(tRRD_CYCLES + 2);
  localparam int CCD_W = $clog2(tCCD_CYCLES + 2);
  localparam logic [RRD_W-1:0] RRD_MAX = RRD_W'(tRRD_CYCLES);
  localparam logic [CCD_W-1:0] CCD_MAX = CCD_W'(tCCD_CYCLES);

  logic                 ref_pending;
  logic [BW-1:0]        rr_ptr;
  logic [RRD_W-1:0]     rrd_cnt;
  logic [CCD_W-1:0]     ccd_cnt;

  logic                 rrd_ok;
  logic                 ccd_ok;
  logic [NUM_BANKS-1:0] elig;
  logic [2:0]           code;
  logic                 tok;
  logic [BW-1:0]        cand;
  logic                 found;
  logic [BW-1:0]        sel;
  logic [2:0]           sel_code;
  logic                 do_grant;
  logic                 act_fire;
  logic                 cas_fire;

  logic                 n_valid;
  logic [2:0]           n_type;
  logic [BW-1:0]        n_bank;
  logic [AW-1:0]        n_addr;
  logic [NUM_BANKS-1:0] n_grant;
  logic                 n_ref;
  logic [BW-1:0]        n_rr;

  // counters hold cycles since the last issue; next issue lands one later
  assign rrd_ok = (int'(rrd_cnt) + 1 >= tRRD_CYCLES);
  assign ccd_ok = (int'(ccd_cnt) + 1 >= tCCD_CYCLES);

  always_comb begin
    elig = '0;
    code = '0;
    tok  = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      code = bank_cmd[3*b +: 3];
      case (code)
        C_ACT:      tok = ~refresh_imminent & rrd_ok;
        C_RD, C_WR: tok = ccd_ok;
        C_PRE:      tok = 1'b1;
        default:    tok = 1'b0;
      endcase
      elig[b] = bank_req[b] & ~bank_grant[b] & tok;
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      cand = BW'((int'(rr_ptr) + i) % NUM_BANKS);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign sel_code = bank_cmd[3*sel +: 3];
  assign do_grant = found & ~ref_pending & ~refresh_cmd_valid;
  assign act_fire = do_grant & (sel_code == C_ACT);
  assign cas_fire = do_grant & ((sel_code == C_RD) | (sel_code == C_WR));

  always_comb begin
    n_valid = 1'b0;
    n_type  = '0;
    n_bank  = '0;
    n_addr  = '0;
    n_grant = '0;
    n_ref   = 1'b0;
    n_rr    = rr_ptr;
    unique case (1'b1)
      ref_pending: begin
        n_valid = 1'b1;
        n_type  = C_REF;
        n_ref   = 1'b1;
      end
      do_grant: begin
        n_valid      = 1'b1;
        n_type       = sel_code;
        n_bank       = sel;
        n_grant[sel] = 1'b1;
        n_rr = (int'(sel) + 1 == NUM_BANKS) ? '0 : BW'(int'(sel) + 1);
        if (sel_code == C_ACT)
          n_addr = AW'(bank_row[ROW_W*sel +: ROW_W]);
        else if (sel_code == C_RD || sel_code == C_WR)
          n_addr = AW'(bank_col[COL_W*sel +: COL_W]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_pending    <= 1'b0;
      rr_ptr         <= '0;
      rrd_cnt        <= RRD_MAX;
      ccd_cnt        <= CCD_MAX;
      cmd_valid      <= 1'b0;
      cmd_type       <= '0;
      cmd_bank       <= '0;
      cmd_addr       <= '0;
      bank_grant     <= '0;
      refresh_issued <= 1'b0;
    end else begin
      // a pulse during a pending REF is absorbed as it issues
      ref_pending    <= refresh_cmd_valid & ~ref_pending;
      rr_ptr         <= n_rr;
      rrd_cnt        <= act_fire ? '0 :
                        (rrd_cnt == RRD_MAX) ? RRD_MAX : rrd_cnt + 1'b1;
      ccd_cnt        <= cas_fire ? '0 :
                        (ccd_cnt == CCD_MAX) ? CCD_MAX : ccd_cnt + 1'b1;
      cmd_valid      <= n_valid;
      cmd_type       <= n_type;
      cmd_bank       <= n_bank;
      cmd_addr       <= n_addr;
      bank_grant     <= n_grant;
      refresh_issued <= n_ref;
    end
  end

endmodule
